// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the "010111" sync-pattern link: preamble constant,
// FSM state encoding and a counter-width helper.
package serial_pattern_tx_pkg;

    localparam int unsigned SYNC_PRE_W = 6;
    localparam logic [SYNC_PRE_W-1:0] SYNC_PREAMBLE = 6'b010111;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_PRE  = 4'b0010,
        S_DATA = 4'b0100,
        S_GAP  = 4'b1000
    } state_t;

    // Bits needed to count down from the largest of three phase lengths.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_piso_shift.sv
// Parallel-load, MSB-first shift register feeding the serial payload bits.
module serial_pattern_tx_piso_shift #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_msb
);

    logic [DATA_W-1:0] r_shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= r_shift << 1;
        end
    end

    assign o_msb = r_shift[DATA_W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Bit-serial frame transmitter: preamble, MSB-first payload, then idle-high gap.
// Line outputs are registered from the next-state decode, so bits lag the accept by one cycle.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       PRE_W      = SYNC_PRE_W,
    parameter logic [PRE_W-1:0]  PREAMBLE   = PRE_W'(SYNC_PREAMBLE),
    parameter int unsigned       GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              d_out,
    output logic              d_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CNT_W = cnt_width(PRE_W, DATA_W, GAP_CYCLES);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             r_d_out;
    logic             r_d_en;
    logic             r_frame_done;
    logic             r_busy;
    logic             w_d_out_nxt;
    logic             w_d_en_nxt;
    logic             w_frame_done_nxt;
    logic             w_load;
    logic             w_shift;
    logic             w_msb;
    logic             w_pre_bit;

    serial_pattern_tx_piso_shift #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (in_data),
        .o_msb   (w_msb)
    );

    assign w_cnt_dec = r_cnt - CNT_W'(1);

    // Preamble bit for the next PRE cycle, selected without an oversized index.
    always_comb begin
        w_pre_bit = 1'b1;
        for (int i = 0; i < int'(PRE_W); i++) begin
            if (CNT_W'(i) == w_cnt_dec) begin
                w_pre_bit = PREAMBLE[i];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_d_out_nxt      = 1'b1;
        w_d_en_nxt       = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_load           = 1'b0;
        w_shift          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = PRE_LAST;
                    w_load      = 1'b1;
                    w_d_out_nxt = PREAMBLE[PRE_W-1];
                    w_d_en_nxt  = 1'b1;
                end
            end
            S_PRE: begin
                w_d_en_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt      = S_DATA;
                    w_cnt_nxt        = DATA_LAST;
                    w_d_out_nxt      = w_msb;
                    w_shift          = 1'b1;
                    w_frame_done_nxt = (DATA_W == 1);
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                    w_d_out_nxt = w_pre_bit;
                end
            end
            S_DATA: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_LAST;
                end else begin
                    w_cnt_nxt        = w_cnt_dec;
                    w_d_out_nxt      = w_msb;
                    w_d_en_nxt       = 1'b1;
                    w_shift          = 1'b1;
                    w_frame_done_nxt = (r_cnt == CNT_W'(1));
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_d_out      <= 1'b1;
            r_d_en       <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_d_out      <= w_d_out_nxt;
            r_d_en       <= w_d_en_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign d_out      = r_d_out;
    assign d_en       = r_d_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: default 8-bit instance plus a
// 16-bit / 3-gap instance, with a behavioural 010111 detector on the 8-bit line.
module tb_serial_pattern_tx;

    localparam int TOT0 = 1 + 6 + 8 + 1;
    localparam int TOT1 = 1 + 6 + 16 + 3;

    typedef struct packed {
        logic d;
        logic fd;
    } exp_t;

    logic [5:0] PRE_BITS = 6'b010111;

    logic        clk;
    logic        rstn;
    logic        v0, rdy0, dout0, den0, busy0, fd0;
    logic [7:0]  d0;
    logic        v1, rdy1, dout1, den1, busy1, fd1;
    logic [15:0] d1;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   det_cnt = 0;
    int   det_cyc = 0;
    logic [5:0] hist = 6'b111111;

    serial_pattern_tx u0 (
        .clk(clk), .rstn(rstn), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
        .d_out(dout0), .d_en(den0), .busy(busy0), .frame_done(fd0)
    );

    serial_pattern_tx #(.DATA_W(16), .GAP_CYCLES(3)) u1 (
        .clk(clk), .rstn(rstn), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .d_out(dout1), .d_en(den1), .busy(busy1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitors: pop an expected bit whenever the line carries one
    always @(negedge clk) begin
        if (rstn) begin
            if (den0) begin
                if (q0.size() == 0) begin
                    chk("u0_unexpected_den", 32'(den0), 0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("u0_bit", 32'(dout0), 32'(e.d));
                    chk("u0_frame_done", 32'(fd0), 32'(e.fd));
                end
            end else begin
                chk("u0_idle_dout", 32'(dout0), 1);
                chk("u0_idle_fd", 32'(fd0), 0);
            end
            if (den1) begin
                if (q1.size() == 0) begin
                    chk("u1_unexpected_den", 32'(den1), 0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("u1_bit", 32'(dout1), 32'(e.d));
                    chk("u1_frame_done", 32'(fd1), 32'(e.fd));
                end
            end else begin
                chk("u1_idle_dout", 32'(dout1), 1);
                chk("u1_idle_fd", 32'(fd1), 0);
            end
        end
    end

    // Behavioural receiver on u0's line
    always @(negedge clk) begin
        if (!rstn) begin
            hist = 6'b111111;
        end else begin
            hist = {hist[4:0], dout0};
            if (hist == PRE_BITS) begin
                det_cnt++;
                det_cyc = cyc;
            end
        end
    end

    // Called just after a negedge with u0 idle; returns at the negedge where in_ready is back.
    task automatic send0(input logic [7:0] data, input bit cont, input bit lb);
        int dc;
        v0 = 1'b1;
        d0 = data;
        chk("u0_ready_at_accept", 32'(rdy0), 1);
        for (int i = 5; i >= 0; i--) q0.push_back(exp_t'{PRE_BITS[i], 1'b0});
        for (int i = 7; i >= 0; i--) q0.push_back(exp_t'{data[i], (i == 0)});
        dc = det_cnt;
        @(posedge clk);
        for (int n = 1; n <= TOT0; n++) begin
            @(negedge clk);
            if (n == 1) acc_cyc = cyc;
            if (!cont) v0 = 1'b0;
            if (n < TOT0) d0 = 8'($urandom);
            chk("u0_in_ready", 32'(rdy0), int'(n == TOT0));
            chk("u0_busy", 32'(busy0), int'(n != TOT0));
        end
        chk("u0_queue_drained", q0.size(), 0);
        if (lb) begin
            chk("lb_det_count", det_cnt - dc, 1);
            chk("lb_det_cycle", det_cyc - acc_cyc + 1, 6);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        v0 = 1'b1;
        d0 = 8'hA5;
        v1 = 1'b0;
        d1 = '0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(rdy0), 1);
            chk("rst_d_out", 32'(dout0), 1);
            chk("rst_d_en", 32'(den0), 0);
            chk("rst_busy", 32'(busy0), 0);
            chk("rst_frame_done", 32'(fd0), 0);
        end
        @(negedge clk);
        v0 = 1'b0;
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(rdy0), 1);
            chk("post_rst_d_en", 32'(den0), 0);
            chk("post_rst_busy", 32'(busy0), 0);
        end

        send0(8'hA5, 1'b0, 1'b0);

        send0(8'h00, 1'b1, 1'b0);
        send0(8'hFF, 1'b1, 1'b0);
        v0 = 1'b0;
        @(negedge clk);

        repeat (3) send0(8'h00, 1'b0, 1'b1);
        @(negedge clk);

        // Reset in cycle 10 of a frame
        v0 = 1'b1;
        d0 = 8'h5A;
        for (int i = 5; i >= 0; i--) q0.push_back(exp_t'{PRE_BITS[i], 1'b0});
        for (int i = 7; i >= 0; i--) q0.push_back(exp_t'{d0[i], (i == 0)});
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            v0 = 1'b0;
        end
        #2 rstn = 1'b0;
        #1;
        chk("midrst_d_out", 32'(dout0), 1);
        chk("midrst_d_en", 32'(den0), 0);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_in_ready", 32'(rdy0), 1);
        q0.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_idle_d_en", 32'(den0), 0);
            chk("midrst_idle_ready", 32'(rdy0), 1);
        end
        send0(8'h3C, 1'b0, 1'b0);

        // Wide instance: 16-bit payload, 3 gap cycles
        v1 = 1'b1;
        d1 = 16'h8001;
        chk("u1_ready_at_accept", 32'(rdy1), 1);
        for (int i = 5; i >= 0; i--) q1.push_back(exp_t'{PRE_BITS[i], 1'b0});
        for (int i = 15; i >= 0; i--) q1.push_back(exp_t'{d1[i], (i == 0)});
        @(posedge clk);
        for (int n = 1; n <= TOT1; n++) begin
            @(negedge clk);
            v1 = 1'b0;
            d1 = 16'($urandom);
            chk("u1_in_ready", 32'(rdy1), int'(n == TOT1));
            chk("u1_busy", 32'(busy1), int'(n != TOT1));
        end
        chk("u1_queue_drained", q1.size(), 0);

        repeat (3) @(negedge clk);
        chk("final_q0_empty", q0.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
